// File: rtl/ttt_event_tx.sv
// Event transmitter: queues one-cycle core events in a small FIFO and ships
// each as an 8-bit {kind,id} word over a 4-phase req/ack handshake.
module ttt_event_tx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     ev_valid,
  input  logic [1:0]               ev_kind,
  input  logic [5:0]               ev_id,
  output logic [7:0]               tx_data,
  output logic                     tx_req,
  input  logic                     tx_ack,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_e;

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [7:0]             tx_data_q;
  logic                   tx_req_q;
  logic                   ack_s, full, push, pop;

  assign ack_s = sync_q[SYNC_STAGES-1];
  // Fullness uses the pre-edge count, so a same-edge pop never rescues a push.
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign push  = ev_valid & ~full;
  assign pop   = (state_q == IDLE) & ena & (cnt_q != '0) & ~ack_s;

  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = ovf_q;
    if (clr_overflow)   ovf_d = 1'b0;
    if (ev_valid & full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], tx_ack};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ev_kind, ev_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          tx_data_q <= mem_q[rd_ptr_q];
          tx_req_q  <= 1'b1;
          state_q   <= REQ;
        end
        REQ: if (ack_s) begin
          tx_req_q <= 1'b0;
          state_q  <= WAIT_LOW;
        end
        WAIT_LOW: if (!ack_s) state_q <= IDLE;
        default: begin
          tx_req_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_req   = tx_req_q;
  assign overflow = ovf_q;
  assign level    = cnt_q;

endmodule
